fib_seq_engine: RTL

//  Parametrised Fibonacci-class sequence engine. It computes term n of a
//  2-term additive recurrence x(k) = x(k-1) + x(k-2) with selectable seeds:

---
 rtl/fib_pkg.sv | 15 +
 rtl/fib_sat_adder.sv | 16 +
 rtl/fib_seq_engine.sv | 74 +++++++
 3 files changed

// File: rtl/fib_pkg.sv
// fib_pkg: shared modes, FSM state codes and seed constants for the Fibonacci-class engine
package fib_pkg;
    typedef enum logic [1:0] {
        MODE_FIB    = 2'b00,
        MODE_LUCAS  = 2'b01,
        MODE_CUSTOM = 2'b10
    } mode_t;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;
    localparam int FIB_S0   = 0;
    localparam int FIB_S1   = 1;
    localparam int LUCAS_S0 = 2;
    localparam int LUCAS_S1 = 1;
endpackage

// File: rtl/fib_sat_adder.sv
// fib_sat_adder: WIDTH-bit add with carry-out and optional sticky clamp to all-ones
module fib_sat_adder #(
    parameter int WIDTH    = 16,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sat_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    logic [WIDTH-1:0] raw;
    assign {carry, raw} = a + b;
    // sat_in keeps later terms pinned once an earlier term has clamped
    assign sum = (SATURATE != 0 && (carry || sat_in)) ? '1 : raw;
endmodule

// File: rtl/fib_seq_engine.sv
// fib_seq_engine: computes term n of x(k)=x(k-1)+x(k-2) with Fibonacci, Lucas or custom seeds
module fib_seq_engine
    import fib_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int IDX_W    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);
    logic [1:0]       state, nxt;
    logic [WIDTH-1:0] a, b, sum, s0, s1;
    logic [IDX_W-1:0] k, n_q;
    logic             acc, carry;

    fib_sat_adder #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_add (
        .a(a), .b(b), .sat_in(acc), .sum(sum), .carry(carry)
    );

    always_comb begin
        s0 = mode == MODE_LUCAS ? WIDTH'(LUCAS_S0) : mode == MODE_CUSTOM ? seed0 : WIDTH'(FIB_S0);
        s1 = mode == MODE_LUCAS ? WIDTH'(LUCAS_S1) : mode == MODE_CUSTOM ? seed1 : WIDTH'(FIB_S1);
        nxt = state == ST_IDLE ? (start ? (n <= IDX_W'(1) ? ST_FIN : ST_RUN) : ST_IDLE)
            : state == ST_RUN  ? (abort ? ST_IDLE : (k + IDX_W'(1) == n_q ? ST_FIN : ST_RUN))
            : ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            a        <= '0;
            b        <= '0;
            k        <= '0;
            n_q      <= '0;
            acc      <= 1'b0;
        end else begin
            state <= nxt;
            busy  <= nxt != ST_IDLE;
            done  <= state == ST_FIN;
            if (state == ST_IDLE && start) begin
                n_q <= n;
                a   <= s0;
                b   <= s1;
                k   <= IDX_W'(1);
                acc <= 1'b0;
            end
            if (state == ST_RUN) begin
                a   <= b;
                b   <= sum;
                k   <= k + IDX_W'(1);
                acc <= acc | carry;
            end
            if (state == ST_FIN) begin
                result   <= n_q == '0 ? a : b;
                overflow <= acc;
            end
        end
    end
endmodule
